// File: rtl/mat_switch_pkg.sv
// Shared types and defaults for the matrix-core vector switch.
package mat_switch_pkg;

    localparam int DEF_CORE_SIZE    = 4;
    localparam int DEF_SWITCH_WIDTH = 16;
    localparam int DEF_WORD_BITS    = 32;
    localparam int DEF_QUEUE_DEPTH  = 2;

    // One word is an IEEE single bit pattern, carried opaquely.
    typedef logic [DEF_WORD_BITS-1:0]             word_t;
    typedef word_t [DEF_SWITCH_WIDTH-1:0]         vec_t;
    typedef logic [$clog2(DEF_CORE_SIZE)-1:0]     core_idx_t;

    // Pointer width that stays legal for a single-entry queue.
    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mat_switch_queue.sv
// One (source, destination) mailbox: circular FIFO with registered count.
module mat_switch_queue
    import mat_switch_pkg::*;
#(
    parameter  int DATA_BITS = DEF_SWITCH_WIDTH * DEF_WORD_BITS,
    parameter  int DEPTH     = DEF_QUEUE_DEPTH,
    localparam int PTR_W     = ptr_bits(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] push_data,
    output logic                 full,
    output logic                 empty,
    output logic [DATA_BITS-1:0] head,
    output logic [CNT_W-1:0]     count
);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic                 do_push;
    logic                 do_pop;

    // Pointers wrap at DEPTH-1 so non power-of-two depths work.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; stale entries are never visible past count.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping; push+pop together keeps count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mat_switch_fabric.sv
// All-to-all buffered vector switch: one mailbox per (source, destination).
module mat_switch_fabric
    import mat_switch_pkg::*;
#(
    parameter  int SWITCH_CORE_SIZE      = DEF_CORE_SIZE,
    parameter  int SWITCH_WIDTH          = DEF_SWITCH_WIDTH,
    parameter  int WORD_BITS             = DEF_WORD_BITS,
    parameter  int QUEUE_DEPTH           = DEF_QUEUE_DEPTH,
    localparam int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
    input  logic                                                        clock,
    input  logic                                                        reset,
    input  logic [SWITCH_CORE_SIZE-1:0]                                 switch_send_ready,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]      switch_send_core_idx,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][WORD_BITS-1:0] switch_send_data,
    output logic [SWITCH_CORE_SIZE-1:0]                                 switch_send_ok,
    input  logic [SWITCH_CORE_SIZE-1:0]                                 switch_recv_request,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]      switch_recv_core_idx,
    output logic [SWITCH_CORE_SIZE-1:0]                                 switch_recv_ready,
    output logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][WORD_BITS-1:0] switch_recv_data,
    output logic                                                        busy
);

    localparam int N        = SWITCH_CORE_SIZE;
    localparam int VEC_BITS = SWITCH_WIDTH * WORD_BITS;
    localparam int CNT_W    = $clog2(QUEUE_DEPTH + 1);

    // All mailbox arrays are indexed [source][destination].
    logic [N-1:0][N-1:0]                q_push;
    logic [N-1:0][N-1:0]                q_pop;
    logic [N-1:0][N-1:0]                q_full;
    logic [N-1:0][N-1:0]                q_empty;
    logic [N-1:0][N-1:0][VEC_BITS-1:0]  q_head;
    logic [N-1:0][N-1:0][CNT_W-1:0]     q_count;

    for (genvar s = 0; s < N; s++) begin : g_src
        for (genvar d = 0; d < N; d++) begin : g_dst
            mat_switch_queue #(
                .DATA_BITS (VEC_BITS),
                .DEPTH     (QUEUE_DEPTH)
            ) u_q (
                .clock     (clock),
                .reset     (reset),
                .push      (q_push[s][d]),
                .pop       (q_pop[s][d]),
                .push_data (switch_send_data[s]),
                .full      (q_full[s][d]),
                .empty     (q_empty[s][d]),
                .head      (q_head[s][d]),
                .count     (q_count[s][d])
            );
        end
    end

    // Push decode: accept only on registered fullness, so a same-cycle
    // pop never frees space combinationally for another core.
    always_comb begin
        switch_send_ok = '0;
        q_push         = '0;
        for (int s = 0; s < N; s++) begin
            for (int d = 0; d < N; d++) begin
                if (reset && switch_send_ready[s] && !q_full[s][d] &&
                    switch_send_core_idx[s] == SWITCH_CORE_ADDR_SIZE'(d)) begin
                    switch_send_ok[s] = 1'b1;
                    q_push[s][d]      = 1'b1;
                end
            end
        end
    end

    // Pop mux: data is forced to zero unless the pop is actually served.
    always_comb begin
        switch_recv_ready = '0;
        switch_recv_data  = '0;
        q_pop             = '0;
        for (int d = 0; d < N; d++) begin
            for (int s = 0; s < N; s++) begin
                if (reset && switch_recv_request[d] && !q_empty[s][d] &&
                    switch_recv_core_idx[d] == SWITCH_CORE_ADDR_SIZE'(s)) begin
                    switch_recv_ready[d] = 1'b1;
                    switch_recv_data[d]  = q_head[s][d];
                    q_pop[s][d]          = 1'b1;
                end
            end
        end
    end

    // Busy straight from the count registers (cleared by async reset).
    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < N; s++) begin
            for (int d = 0; d < N; d++) begin
                if (q_count[s][d] != '0) busy = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mat_switch_fabric.sv
// Directed bench: basic path, backpressure, concurrency, corners, wrap, reset.
module tb_mat_switch_fabric;
    import mat_switch_pkg::*;

    localparam int N = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Depth-2 instance
    logic [N-1:0]            s_rdy, s_ok, r_req, r_rdy;
    core_idx_t [N-1:0]       s_idx, r_idx;
    vec_t [N-1:0]            s_dat, r_dat;
    logic                    busy;
    // Depth-3 instance (wrap-around)
    logic [N-1:0]            s_rdy3, s_ok3, r_req3, r_rdy3;
    core_idx_t [N-1:0]       s_idx3, r_idx3;
    vec_t [N-1:0]            s_dat3, r_dat3;
    logic                    busy3;

    int n_assert = 0;
    int n_fail   = 0;

    mat_switch_fabric #(.QUEUE_DEPTH(2)) dut2 (
        .clock(clock), .reset(reset),
        .switch_send_ready(s_rdy), .switch_send_core_idx(s_idx), .switch_send_data(s_dat),
        .switch_send_ok(s_ok),
        .switch_recv_request(r_req), .switch_recv_core_idx(r_idx),
        .switch_recv_ready(r_rdy), .switch_recv_data(r_dat),
        .busy(busy)
    );

    mat_switch_fabric #(.QUEUE_DEPTH(3)) dut3 (
        .clock(clock), .reset(reset),
        .switch_send_ready(s_rdy3), .switch_send_core_idx(s_idx3), .switch_send_data(s_dat3),
        .switch_send_ok(s_ok3),
        .switch_recv_request(r_req3), .switch_recv_core_idx(r_idx3),
        .switch_recv_ready(r_rdy3), .switch_recv_data(r_dat3),
        .busy(busy3)
    );

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input vec_t obs, input vec_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        s_rdy = '0; s_idx = '0; s_dat = '0; r_req = '0; r_idx = '0;
        s_rdy3 = '0; s_idx3 = '0; s_dat3 = '0; r_req3 = '0; r_idx3 = '0;
    endtask

    // Vector {1.0, 2.0, ..., 16.0} as single-precision bit patterns.
    function automatic vec_t fvec();
        vec_t v;
        for (int i = 0; i < 16; i++) begin
            int n = i + 1;
            int e = 0;
            while ((n >> (e + 1)) != 0) e++;
            v[i] = word_t'(((127 + e) << 23) | ((n << (23 - e)) & 32'h7FFFFF));
        end
        return v;
    endfunction

    function automatic vec_t mkvec(input int seed);
        vec_t v;
        for (int w = 0; w < 16; w++) v[w] = word_t'(seed * 65536 + w * 4097 + 1);
        return v;
    endfunction

    // One cycle on Q[1][2] of the depth-3 instance.
    task automatic wstep(input bit push, input int pid, input bit pop,
                         input bit eok, input bit erdy, input int eid);
        s_rdy3[1] = push; s_idx3[1] = 2'd2; s_dat3[1] = mkvec(500 + pid);
        r_req3[2] = pop;  r_idx3[2] = 2'd1;
        #1;
        chk4("wrap ok",  {3'b000, s_ok3[1]},  {3'b000, eok});
        chk4("wrap rdy", {3'b000, r_rdy3[2]}, {3'b000, erdy});
        chkv("wrap data", r_dat3[2], erdy ? mkvec(500 + eid) : '0);
        tick();
    endtask

    initial begin
        // Reset: outputs held at zero even with requests asserted
        reset = 1'b0;
        idle();
        s_rdy = 4'hF; r_req = 4'hF;
        #1;
        chk4("rst ok", s_ok, 4'h0);
        chk4("rst rdy", r_rdy, 4'h0);
        chk4("rst busy", {3'b000, busy}, 4'h0);
        chkv("rst data", r_dat[0], '0);
        idle();
        tick(); tick();
        reset = 1'b1;

        // Basic path 0 -> 2
        s_rdy[0] = 1'b1; s_idx[0] = 2'd2; s_dat[0] = fvec();
        #1;
        chk4("basic ok", s_ok, 4'b0001);
        chk4("basic busy0", {3'b000, busy}, 4'h0);
        tick();
        idle();
        r_req[2] = 1'b1; r_idx[2] = 2'd0;
        #1;
        chk4("basic rdy", r_rdy, 4'b0100);
        chkv("basic data", r_dat[2], fvec());
        chk4("basic busy1", {3'b000, busy}, 4'h1);
        tick();
        idle();
        #1;
        chk4("basic busy2", {3'b000, busy}, 4'h0);
        chk4("basic rdy2", r_rdy, 4'h0);
        chkv("basic data2", r_dat[2], '0);

        // Fill / backpressure on Q[1][3]
        s_rdy[1] = 1'b1; s_idx[1] = 2'd3; s_dat[1] = mkvec(10);
        #1; chk4("fill A ok", s_ok, 4'b0010); tick();
        s_dat[1] = mkvec(11);
        #1; chk4("fill B ok", s_ok, 4'b0010); tick();
        s_dat[1] = mkvec(12);
        #1; chk4("fill C held", s_ok, 4'h0); tick();
        #1; chk4("fill C held2", s_ok, 4'h0);
        r_req[3] = 1'b1; r_idx[3] = 2'd1;
        #1;
        chk4("fill pop A rdy", r_rdy, 4'b1000);
        chkv("fill pop A", r_dat[3], mkvec(10));
        chk4("fill full+pop", s_ok, 4'h0);
        tick();
        r_req[3] = 1'b0;
        #1; chk4("fill C ok", s_ok, 4'b0010); tick();
        s_rdy[1] = 1'b0; r_req[3] = 1'b1;
        #1; chkv("fill pop B", r_dat[3], mkvec(11)); tick();
        #1;
        chk4("fill pop C rdy", r_rdy, 4'b1000);
        chkv("fill pop C", r_dat[3], mkvec(12));
        tick();
        #1; chk4("fill empty", r_rdy, 4'h0);
        idle();

        // Concurrency: s -> (s+1)%4 every cycle, all destinations popping
        for (int k = 0; k <= 20; k++) begin
            for (int s = 0; s < N; s++) begin
                s_rdy[s] = (k < 20);
                s_idx[s] = core_idx_t'((s + 1) % N);
                s_dat[s] = mkvec(s * 64 + k);
                r_req[s] = 1'b1;
                r_idx[s] = core_idx_t'((s + 3) % N);
            end
            #1;
            chk4("conc ok", s_ok, (k < 20) ? 4'hF : 4'h0);
            chk4("conc rdy", r_rdy, (k >= 1) ? 4'hF : 4'h0);
            chk4("conc busy", {3'b000, busy}, {3'b000, k >= 1});
            if (k >= 1)
                for (int d = 0; d < N; d++)
                    chkv("conc data", r_dat[d], mkvec(((d + 3) % N) * 64 + k - 1));
            tick();
        end
        idle();
        #1; chk4("conc drained", {3'b000, busy}, 4'h0);

        // Empty queue with same-cycle push: pop waits one cycle
        s_rdy[0] = 1'b1; s_idx[0] = 2'd1; s_dat[0] = mkvec(700);
        r_req[1] = 1'b1; r_idx[1] = 2'd0;
        #1;
        chk4("empty rdy0", r_rdy, 4'h0);
        chk4("empty ok", s_ok, 4'b0001);
        tick();
        s_rdy[0] = 1'b0;
        #1;
        chk4("empty rdy1", r_rdy, 4'b0010);
        chkv("empty data", r_dat[1], mkvec(700));
        tick();
        idle();

        // Loopback 2->2 alongside 0->2
        s_rdy[2] = 1'b1; s_idx[2] = 2'd2; s_dat[2] = mkvec(710);
        s_rdy[0] = 1'b1; s_idx[0] = 2'd2; s_dat[0] = mkvec(711);
        #1; chk4("loop ok", s_ok, 4'b0101);
        tick();
        idle();
        r_req[2] = 1'b1; r_idx[2] = 2'd2;
        #1;
        chk4("loop rdy", r_rdy, 4'b0100);
        chkv("loop data", r_dat[2], mkvec(710));
        tick();
        r_idx[2] = 2'd0;
        #1; chkv("loop other", r_dat[2], mkvec(711)); tick();
        r_idx[2] = 2'd2;
        #1; chk4("loop empty", r_rdy, 4'h0);
        idle();
        tick();

        // Wrap-around on depth-3 queue Q[1][2]
        wstep(1, 0, 0, 1, 0, 0);
        wstep(1, 1, 0, 1, 0, 0);
        wstep(1, 2, 0, 1, 0, 0);
        wstep(1, 3, 1, 0, 1, 0);
        wstep(1, 3, 1, 1, 1, 1);
        wstep(1, 4, 1, 1, 1, 2);
        wstep(1, 5, 0, 1, 0, 0);
        wstep(1, 6, 1, 0, 1, 3);
        wstep(1, 6, 1, 1, 1, 4);
        wstep(0, 0, 1, 0, 1, 5);
        wstep(0, 0, 1, 0, 1, 6);
        wstep(0, 0, 1, 0, 0, 0);
        idle();
        #1; chk4("wrap busy", {3'b000, busy3}, 4'h0);

        // Reset mid-stream with Q[0][1] and Q[2][3] holding data
        s_rdy[0] = 1'b1; s_idx[0] = 2'd1; s_dat[0] = mkvec(900);
        s_rdy[2] = 1'b1; s_idx[2] = 2'd3; s_dat[2] = mkvec(901);
        tick();
        idle();
        r_req[1] = 1'b1; r_idx[1] = 2'd0;
        #1;
        chk4("mid busy", {3'b000, busy}, 4'h1);
        chk4("mid rdy", r_rdy, 4'b0010);
        chkv("mid data", r_dat[1], mkvec(900));
        reset = 1'b0;
        s_rdy = 4'hF;
        #1;
        chk4("mid rst ok", s_ok, 4'h0);
        chk4("mid rst rdy", r_rdy, 4'h0);
        chkv("mid rst data", r_dat[1], '0);
        chk4("mid rst busy", {3'b000, busy}, 4'h0);
        tick();
        chk4("mid rst held", r_rdy, 4'h0);
        reset = 1'b1;
        s_rdy = 4'h0;
        r_req = 4'b1010; r_idx[1] = 2'd0; r_idx[3] = 2'd2;
        #1;
        chk4("post rst rdy", r_rdy, 4'h0);
        chk4("post rst busy", {3'b000, busy}, 4'h0);
        tick();
        chk4("post rst rdy2", r_rdy, 4'h0);
        s_rdy[0] = 1'b1; s_idx[0] = 2'd1; s_dat[0] = mkvec(902);
        #1; chk4("post rst ok", s_ok, 4'b0001);
        tick();
        s_rdy = 4'h0;
        #1;
        chk4("post rst pop", r_rdy, 4'b0010);
        chkv("post rst data", r_dat[1], mkvec(902));
        tick();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mat_switch_fabric.md
Name: mat_switch_fabric

Overview:
- Buffered all-to-all vector switch between SWITCH_CORE_SIZE matrix cores.
- Each core pushes a SWITCH_WIDTH-word vector tagged with a destination core index, and pops vectors by naming a source core index.
- One FIFO mailbox per (source, destination) pair, QUEUE_DEPTH entries deep. This replaces the single-slot, single-core switch endpoint.
- Sits beside the MatCore array. Each core's switch_send_* / switch_recv_* signals connect to one slice of this block.

Parameters:
- SWITCH_CORE_SIZE, 4: number of attached cores (≥2).
- SWITCH_WIDTH, 16: words per vector.
- WORD_BITS, 32: bits per word (IEEE single bit pattern; treated as opaque by the switch).
- QUEUE_DEPTH, 2: entries per mailbox (≥1, need not be a power of 2).
- SWITCH_CORE_ADDR_SIZE, $clog2(SWITCH_CORE_SIZE): derived, not overridden.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- switch_send_ready  in  [SWITCH_CORE_SIZE]  per-source push request.
- switch_send_core_idx  in  [SWITCH_CORE_SIZE][SWITCH_CORE_ADDR_SIZE]  destination index per source.
- switch_send_data  in  [SWITCH_CORE_SIZE][SWITCH_WIDTH][WORD_BITS]  vector per source.
- switch_send_ok  out  [SWITCH_CORE_SIZE]  push accepted this cycle.
- switch_recv_request  in  [SWITCH_CORE_SIZE]  per-destination pop request.
- switch_recv_core_idx  in  [SWITCH_CORE_SIZE][SWITCH_CORE_ADDR_SIZE]  source index per destination.
- switch_recv_ready  out  [SWITCH_CORE_SIZE]  pop performed this cycle; data valid.
- switch_recv_data  out  [SWITCH_CORE_SIZE][SWITCH_WIDTH][WORD_BITS]  popped vector.
- busy  out  1  any mailbox non-empty.

Behaviour:
- Mailbox Q[s][d]: circular buffer with rd_ptr, wr_ptr and count (0..QUEUE_DEPTH). Pointers wrap from QUEUE_DEPTH-1 to 0.
- Push, source s, d = switch_send_core_idx[s]:
  - switch_send_ok[s] = reset & switch_send_ready[s] & (count[s][d] != QUEUE_DEPTH). Combinational, depends only on registered count.
  - On a rising edge with send_ok set, data is written at wr_ptr and the entry becomes visible from the next cycle.
  - A full queue refuses the push even if a pop of the same queue occurs in the same cycle. This avoids a combinational path between cores.
- Pop, destination d, s = switch_recv_core_idx[d]:
  - switch_recv_ready[d] = reset & switch_recv_request[d] & (count[s][d] != 0).
  - switch_recv_data[d] = head of Q[s][d] when recv_ready is high, all zeros otherwise.
  - The pop commits on the rising edge.
- Latency: a push at edge N can be popped in the cycle after edge N, i.e. one clock minimum. Throughput is 1 vector/cycle per source and per destination simultaneously.
- Simultaneous push and pop on the same non-full, non-empty queue: count unchanged, both pointers advance.
- Simultaneous push and pop on an empty queue: the pop is not served (recv_ready=0); the push is stored.
- Loopback (s == d) is a legal, independent queue.
- FIFO order is preserved per (s,d). There is no ordering between different sources.
- Requesters hold send/recv requests until ok/ready. Changing idx/data while a request is unacknowledged is legal; the value sampled on the accepting edge wins.
- busy = OR over all count != 0, registered from count.
- Reset (reset=0, async):
  - All counts and pointers go to 0.
  - switch_send_ok, switch_recv_ready, switch_recv_data and busy go to 0 immediately and stay 0 while reset is held.
  - Any in-flight vectors are discarded.
  - Storage contents are don't-care and need no reset.
- No overflow/underflow is possible by construction.

Decomposition:
- Package mat_switch_pkg holds:
  - WORD_BITS default;
  - typedef word_t = logic [WORD_BITS-1:0];
  - typedef vec_t = word_t [SWITCH_WIDTH-1:0];
  - the core index type.
- Sub-module mat_switch_queue: one parametrised FIFO with push/pop/full/empty/head/count and async active-low reset.
- mat_switch_fabric instantiates SWITCH_CORE_SIZE² queues in a generate loop, plus push-decode and pop-mux logic.

Test Plan:
- Basic path: core 0 sends vector {1.0, 2.0, …, 16.0} to core 2, then core 2 requests src 0 → send_ok[0]=1 on push cycle; recv_ready[2]=1 one cycle later with identical bits; busy 1→0.
- Fill/backpressure, QUEUE_DEPTH=2: core 1 pushes A, B, C to core 3 → ok for A, B; C held (ok=0) until core 3 pops A; then C accepted; pops return A, B, C in order.
- Concurrency: all 4 cores send to (s+1)%4 every cycle while all pop continuously for 20 cycles → 20 vectors per pair, no loss or reorder, counts steady.
- Empty/corner: pop on empty Q[0][1] with a same-cycle push → recv_ready=0 that cycle and 1 the next. Loopback 2→2 works independently of 0→2.
- Wrap-around, QUEUE_DEPTH=3: push/pop 7 vectors on one queue with interleaved stalls → pointers wrap twice, data intact.
- Reset mid-stream: with 2 queues holding data, drive reset=0 between edges → outputs 0 immediately, busy=0; after release, pops return recv_ready=0 until new pushes.
